// File: rtl/axicb_slv_switch_rd_n.sv
`default_nettype none
// ============================================================================
// Module   : axicb_slv_switch_rd_n
// Brief    : AXI read switch. Decodes AR to N slaves, returns R in issue
//            order and generates local DECERR bursts for unmapped reads.
//            Optional stall monitor enabled by macro AXICB_RD_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================

module axicb_slv_switch_rd_n #(
    parameter int                           AXI_ADDR_W     = 8,
    parameter int                           AXI_ID_W       = 8,
    parameter int                           AXI_SIGNALING  = 0,
    parameter int                           SLV_NB         = 4,
    parameter logic [SLV_NB-1:0]            MST_ROUTES     = '1,
    parameter logic [SLV_NB*AXI_ADDR_W-1:0] SLV_START_ADDR = '0,
    parameter logic [SLV_NB*AXI_ADDR_W-1:0] SLV_END_ADDR   = '0,
    parameter int                           OSTD_DEPTH     = 8,
    parameter int                           TIMEOUT_CYCLES = 1024,
    parameter int                           ARCH_W         = 8,
    parameter int                           RCH_W          = 8
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic                    i_arvalid,
    output logic                    i_arready,
    input  logic [ARCH_W-1:0]       i_arch,
    output logic                    i_rvalid,
    input  logic                    i_rready,
    output logic                    i_rlast,
    output logic [RCH_W-1:0]        i_rch,
    output logic [SLV_NB-1:0]       o_arvalid,
    input  logic [SLV_NB-1:0]       o_arready,
    output logic [ARCH_W-1:0]       o_arch,
    input  logic [SLV_NB-1:0]       o_rvalid,
    output logic [SLV_NB-1:0]       o_rready,
    input  logic [SLV_NB-1:0]       o_rlast,
    input  logic [SLV_NB*RCH_W-1:0] o_rch,
    output logic                    o_timeout
);

    localparam int c_SEL_W   = (SLV_NB > 1) ? $clog2(SLV_NB) : 1;
    localparam int c_PTR_W   = $clog2(OSTD_DEPTH);
    localparam int c_CNT_W   = c_PTR_W + 1;
    localparam int c_LEN_OFS = AXI_ADDR_W + AXI_ID_W;
    localparam int c_AREXT_W = (ARCH_W > c_LEN_OFS + 8) ? ARCH_W : c_LEN_OFS + 8;
    localparam int c_REXT_W  = (RCH_W > AXI_ID_W + 2) ? RCH_W : AXI_ID_W + 2;
    localparam logic [c_CNT_W-1:0] c_FULL_LVL = c_CNT_W'(OSTD_DEPTH);

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_FWD    = 2'd1;
    localparam logic [1:0] c_ST_DECERR = 2'd2;

    // AR payload widened so field slices stay in range for any ARCH_W
    logic [c_AREXT_W-1:0]  w_ar_ext;
    logic [AXI_ADDR_W-1:0] w_addr;
    logic [AXI_ID_W-1:0]   w_id;
    logic [7:0]            w_len;
    logic [SLV_NB-1:0]     w_hit;
    logic [c_SEL_W-1:0]    w_sel;
    logic                  w_mis;
    logic                  w_full;
    logic                  w_push;
    logic                  w_pop;

    logic                  r_fifo_mis [OSTD_DEPTH];
    logic [c_SEL_W-1:0]    r_fifo_sel [OSTD_DEPTH];
    logic [AXI_ID_W-1:0]   r_fifo_id  [OSTD_DEPTH];
    logic [7:0]            r_fifo_len [OSTD_DEPTH];
    logic [c_PTR_W-1:0]    r_wr_ptr;
    logic [c_PTR_W-1:0]    r_rd_ptr;
    logic [c_CNT_W-1:0]    r_count;

    logic                  w_empty;
    logic                  w_h_mis;
    logic [c_SEL_W-1:0]    w_h_sel;
    logic [AXI_ID_W-1:0]   w_h_id;
    logic [7:0]            w_h_len;
    logic [c_PTR_W-1:0]    w_rd_ptr_inc;
    logic                  w_nxt_avail;
    logic                  w_nxt_mis;

    logic [1:0]            r_state;
    logic [1:0]            w_state_nxt;
    logic [7:0]            r_beat;
    logic [7:0]            w_beat_nxt;
    logic                  w_dec_last;
    logic [c_REXT_W-1:0]   w_rch_ext;

    always_comb begin
        w_ar_ext               = '0;
        w_ar_ext[ARCH_W-1:0]   = i_arch;
    end

    assign w_addr = w_ar_ext[AXI_ADDR_W-1:0];
    assign w_id   = w_ar_ext[AXI_ADDR_W +: AXI_ID_W];

    generate
        if (AXI_SIGNALING != 0) begin : g_axi4
            assign w_len = w_ar_ext[c_LEN_OFS +: 8];
        end else begin : g_lite
            assign w_len = 8'd0;
        end
    endgenerate

    always_comb begin
        w_hit = '0;
        for (int k = 0; k < SLV_NB; k++) begin
            w_hit[k] = MST_ROUTES[k]
                     && (w_addr >= SLV_START_ADDR[k*AXI_ADDR_W +: AXI_ADDR_W])
                     && (w_addr <= SLV_END_ADDR[k*AXI_ADDR_W +: AXI_ADDR_W]);
        end
    end

    // Downward scan so the lowest-index hit wins on overlapping windows
    always_comb begin
        w_sel = '0;
        for (int k = SLV_NB - 1; k >= 0; k--) begin
            if (w_hit[k]) begin
                w_sel = c_SEL_W'(k);
            end
        end
    end

    assign w_mis     = ~|w_hit;
    assign w_full    = (r_count == c_FULL_LVL);
    assign i_arready = aresetn & ~w_full & (w_mis | o_arready[w_sel]);
    assign w_push    = i_arvalid & i_arready;
    assign o_arch    = i_arch;

    always_comb begin
        o_arvalid = '0;
        if (aresetn && i_arvalid && !w_full && !w_mis) begin
            o_arvalid[w_sel] = 1'b1;
        end
    end

    always_ff @(posedge aclk) begin
        if (w_push) begin
            r_fifo_mis[r_wr_ptr] <= w_mis;
            r_fifo_sel[r_wr_ptr] <= w_sel;
            r_fifo_id[r_wr_ptr]  <= w_id;
            r_fifo_len[r_wr_ptr] <= w_len;
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign w_empty      = (r_count == '0);
    assign w_h_mis      = r_fifo_mis[r_rd_ptr];
    assign w_h_sel      = r_fifo_sel[r_rd_ptr];
    assign w_h_id       = r_fifo_id[r_rd_ptr];
    assign w_h_len      = r_fifo_len[r_rd_ptr];
    assign w_rd_ptr_inc = r_rd_ptr + c_PTR_W'(1);

    // Head after a pop: a stored entry, or the request being pushed right now
    assign w_nxt_avail  = (r_count > c_CNT_W'(1)) | w_push;
    assign w_nxt_mis    = (r_count > c_CNT_W'(1)) ? r_fifo_mis[w_rd_ptr_inc] : w_mis;
    assign w_dec_last   = (r_beat == w_h_len);

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_state <= c_ST_IDLE;
            r_beat  <= 8'd0;
        end else begin
            r_state <= w_state_nxt;
            r_beat  <= w_beat_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_beat_nxt  = r_beat;
        w_pop       = 1'b0;
        i_rvalid    = 1'b0;
        i_rlast     = 1'b0;
        w_rch_ext   = '0;
        o_rready    = '0;
        if (aresetn) begin
            case (r_state)
                c_ST_IDLE: begin
                    if (!w_empty) begin
                        w_state_nxt = w_h_mis ? c_ST_DECERR : c_ST_FWD;
                    end
                end
                c_ST_FWD: begin
                    i_rvalid                = o_rvalid[w_h_sel];
                    i_rlast                 = o_rlast[w_h_sel];
                    w_rch_ext[RCH_W-1:0]    = o_rch[w_h_sel*RCH_W +: RCH_W];
                    o_rready[w_h_sel]       = i_rready;
                    w_pop                   = o_rvalid[w_h_sel] & i_rready & o_rlast[w_h_sel];
                end
                c_ST_DECERR: begin
                    i_rvalid                   = 1'b1;
                    i_rlast                    = w_dec_last;
                    w_rch_ext[AXI_ID_W +: 2]   = 2'b11;
                    w_rch_ext[AXI_ID_W-1:0]    = w_h_id;
                    if (i_rready) begin
                        if (w_dec_last) begin
                            w_beat_nxt = 8'd0;
                            w_pop      = 1'b1;
                        end else begin
                            w_beat_nxt = r_beat + 8'd1;
                        end
                    end
                end
                default: w_state_nxt = c_ST_IDLE;
            endcase
            if (w_pop) begin
                w_state_nxt = !w_nxt_avail ? c_ST_IDLE :
                              (w_nxt_mis ? c_ST_DECERR : c_ST_FWD);
            end
        end
    end

    assign i_rch = w_rch_ext[RCH_W-1:0];

`ifdef AXICB_RD_TIMEOUT_EN
    logic [15:0] r_to_cnt;
    logic [15:0] w_to_cnt_nxt;
    logic        r_timeout;

    always_comb begin
        w_to_cnt_nxt = r_to_cnt;
        if (w_empty || (i_rvalid && i_rready)) begin
            w_to_cnt_nxt = 16'd0;
        end else if ((r_state == c_ST_FWD) && !o_rvalid[w_h_sel] && (r_to_cnt != 16'hFFFF)) begin
            w_to_cnt_nxt = r_to_cnt + 16'd1;
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_to_cnt  <= 16'd0;
            r_timeout <= 1'b0;
        end else begin
            r_to_cnt <= w_to_cnt_nxt;
            if (32'(w_to_cnt_nxt) >= TIMEOUT_CYCLES) begin
                r_timeout <= 1'b1;
            end
        end
    end

    assign o_timeout = r_timeout;
`else
    assign o_timeout = 1'b0;
`endif

    logic w_unused;
    assign w_unused = ^{w_ar_ext, w_rch_ext, TIMEOUT_CYCLES};

endmodule

`default_nettype wire
